// File: rtl/mdr_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mdr_sequencer_if                                        |
// | Brief    : Request/operand/core bundle between host and sequencer. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface mdr_sequencer_if #(
  parameter int WORD_LENGTH = 16
) ();
  logic                   i_start;
  logic [1:0]             i_opcode;
  logic                   i_load_data;
  logic [WORD_LENGTH-1:0] i_data;
  logic                   i_core_ready;
  logic                   o_core_start;
  logic [1:0]             o_core_opcode;
  logic [WORD_LENGTH-1:0] o_op_x;
  logic [WORD_LENGTH-1:0] o_op_y;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_error;
  logic [1:0]             o_err_code;

  modport master (
    output i_start, i_opcode, i_load_data, i_data, i_core_ready,
    input  o_core_start, o_core_opcode, o_op_x, o_op_y,
           o_busy, o_done, o_error, o_err_code
  );

  modport slave (
    input  i_start, i_opcode, i_load_data, i_data, i_core_ready,
    output o_core_start, o_core_opcode, o_op_x, o_op_y,
           o_busy, o_done, o_error, o_err_code
  );
endinterface
`default_nettype wire

// File: rtl/mdr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mdr_sequencer                                           |
// | Brief    : Operand-collecting launcher for a mul/div/sqrt core.    |
// |            Optional WAIT watchdog: define MDR_SEQ_WATCHDOG_EN.     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module mdr_sequencer #(
  parameter int WORD_LENGTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic      clk,
  input  wire logic      reset,
  mdr_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_LOAD_Y = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [1:0] c_OP_MUL      = 2'b00;
  localparam logic [1:0] c_OP_DIV      = 2'b01;
  localparam logic [1:0] c_OP_SQRT     = 2'b10;
  localparam logic [1:0] c_OP_ILL      = 2'b11;
  localparam logic [1:0] c_ERR_NONE    = 2'b00;
  localparam logic [1:0] c_ERR_OPCODE  = 2'b01;
  localparam logic [1:0] c_ERR_RANGE   = 2'b10;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;
  localparam logic [WORD_LENGTH-1:0] c_MUL_LIMIT = {1'b1, {(WORD_LENGTH-1){1'b0}}};

  generate
    if (TIMEOUT_CYCLES < 1 || WORD_LENGTH < 2) begin : g_bad_param
      $error("mdr_sequencer: TIMEOUT_CYCLES must be >= 1 and WORD_LENGTH >= 2");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_opcode;
  logic [WORD_LENGTH-1:0] r_op_x;
  logic [WORD_LENGTH-1:0] r_op_y;
  logic [1:0]             r_err_code;
  logic                   w_lat_op;
  logic                   w_lat_x;
  logic                   w_lat_y;
  logic                   w_clr_y;
  logic                   w_set_err;
  logic                   w_clr_err;
  logic [1:0]             w_err_val;
  logic                   w_timeout;

`ifdef MDR_SEQ_WATCHDOG_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_WD_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [c_CNT_W-1:0] r_wd_cnt;

  // Held at zero outside WAIT, so the first WAIT cycle always sees a count of 0.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_WAIT) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == c_WD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_lat_op  = 1'b0;
    w_lat_x   = 1'b0;
    w_lat_y   = 1'b0;
    w_clr_y   = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    w_err_val = c_ERR_NONE;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_opcode == c_OP_ILL) begin
            w_next    = S_ERR;
            w_set_err = 1'b1;
            w_err_val = c_ERR_OPCODE;
          end else begin
            w_next   = S_LOAD_X;
            w_lat_op = 1'b1;
          end
        end
      end
      S_LOAD_X: begin
        if (bus.i_load_data) begin
          w_lat_x = 1'b1;
          if ((r_opcode == c_OP_MUL  && bus.i_data > c_MUL_LIMIT) ||
              (r_opcode == c_OP_SQRT && bus.i_data[WORD_LENGTH-1])) begin
            w_next    = S_ERR;
            w_set_err = 1'b1;
            w_err_val = c_ERR_RANGE;
          end else if (r_opcode == c_OP_SQRT) begin
            w_next  = S_LAUNCH;
            w_clr_y = 1'b1;
          end else begin
            w_next = S_LOAD_Y;
          end
        end
      end
      S_LOAD_Y: begin
        if (bus.i_load_data) begin
          w_lat_y = 1'b1;
          if ((r_opcode == c_OP_MUL && bus.i_data > c_MUL_LIMIT) ||
              (r_opcode == c_OP_DIV && bus.i_data == '0)) begin
            w_next    = S_ERR;
            w_set_err = 1'b1;
            w_err_val = c_ERR_RANGE;
          end else begin
            w_next = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (bus.i_core_ready) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next    = S_ERR;
          w_set_err = 1'b1;
          w_err_val = c_ERR_TIMEOUT;
        end
      end
      S_DONE: w_next = S_IDLE;
      S_ERR: begin
        if (bus.i_start) begin
          w_next    = S_IDLE;
          w_clr_err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode   <= 2'b00;
      r_op_x     <= '0;
      r_op_y     <= '0;
      r_err_code <= c_ERR_NONE;
    end else begin
      if (w_lat_op) r_opcode <= bus.i_opcode;
      if (w_lat_x)  r_op_x   <= bus.i_data;
      if (w_lat_y)  r_op_y   <= bus.i_data;
      else if (w_clr_y) r_op_y <= '0;
      if (w_set_err)      r_err_code <= w_err_val;
      else if (w_clr_err) r_err_code <= c_ERR_NONE;
    end
  end

  // Pulses are masked by reset so an abort in LAUNCH or DONE never escapes.
  assign bus.o_core_start  = (r_state == S_LAUNCH) && !reset;
  assign bus.o_done        = (r_state == S_DONE) && !reset;
  assign bus.o_busy        = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y) ||
                             (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign bus.o_error       = (r_state == S_ERR);
  assign bus.o_err_code    = r_err_code;
  assign bus.o_core_opcode = r_opcode;
  assign bus.o_op_x        = r_op_x;
  assign bus.o_op_y        = r_op_y;
endmodule
`default_nettype wire

// File: tb/tb_mdr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_mdr_sequencer                                        |
// | Brief    : Randomized transaction bench for mdr_sequencer.         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_mdr_sequencer;
  localparam int W    = 16;
  localparam int TO   = 64;
  localparam int HALF = 1 << (W - 1);

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] m_x;
  logic [W-1:0] m_y;

  always #5 clk = ~clk;

  mdr_sequencer_if #(.WORD_LENGTH(W)) bus ();

  mdr_sequencer #(.WORD_LENGTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Outcome of one request: code 0 = completes, else the error code; stage
  // says which step raises it (0 start, 1 first operand, 2 second operand).
  function automatic void predict(input int op, input int x, input int y,
                                  output int code, output int stage);
    code = 0; stage = 3;
    if (op == 3) begin code = 1; stage = 0; end
    else if (op == 0 && x > HALF) begin code = 2; stage = 1; end
    else if (op == 2 && x >= HALF) begin code = 2; stage = 1; end
    else if (op == 0 && y > HALF) begin code = 2; stage = 2; end
    else if (op == 1 && y == 0) begin code = 2; stage = 2; end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return W'(1);
      2: return W'(HALF - 1);
      3: return W'(HALF);
      4: return W'(HALF + 1);
      5: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic quiet();
    bus.i_start = 1'b0; bus.i_load_data = 1'b0; bus.i_core_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; quiet(); tick();
    chk("rst_ctl", {bus.o_core_start, bus.o_busy, bus.o_done, bus.o_error,
                    bus.o_err_code, bus.o_core_opcode}, 0);
    chk("rst_ops", {bus.o_op_x, bus.o_op_y}, 0);
    reset = 1'b0;
    m_x = '0; m_y = '0;
  endtask

  task automatic clear_err();
    bus.i_start = 1'b1; bus.i_opcode = 2'($urandom);
    bus.i_load_data = 1'b1; bus.i_data = W'($urandom);
    tick(); quiet();
    chk("err_clear", {bus.o_error, bus.o_err_code, bus.o_busy}, 0);
    tick();
    chk("err_no_new_op", bus.o_busy, 0);
  endtask

  // Random stall (with stray start requests that must be ignored), then one strobe.
  task automatic load_operand(input logic [W-1:0] v);
    int stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      bus.i_start = 1'($urandom); bus.i_opcode = 2'b11;
      bus.i_load_data = 1'b0; bus.i_data = W'($urandom);
      tick();
    end
    bus.i_start = 1'b0; bus.i_load_data = 1'b1; bus.i_data = v;
    tick();
    bus.i_load_data = 1'b0;
  endtask

  task automatic idle_gap();
    int n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      bus.i_start = 1'b0; bus.i_load_data = 1'($urandom);
      bus.i_data = W'($urandom); bus.i_core_ready = 1'($urandom);
      tick();
    end
    quiet();
    chk("idle_hold", {bus.o_busy, bus.o_op_x, bus.o_op_y}, {1'b0, m_x, m_y});
  endtask

  // Runs a request up to the point the FSM is in LAUNCH; returns 0 if it errored out.
  task automatic issue(input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output bit launched);
    int code, stage;
    launched = 1'b0;
    predict(op, int'(x), int'(y), code, stage);
    quiet();
    bus.i_start = 1'b1; bus.i_opcode = 2'(op);
    bus.i_load_data = 1'b1; bus.i_data = W'($urandom);
    tick(); quiet();
    chk("start_ignores_load", bus.o_op_x, m_x);
    if (stage == 0) begin
      chk("illegal_err", {bus.o_error, bus.o_err_code, bus.o_busy}, {1'b1, 2'(code), 1'b0});
      clear_err();
      return;
    end
    chk("busy_opcode", {bus.o_busy, bus.o_core_opcode}, {1'b1, 2'(op)});
    load_operand(x); m_x = x;
    chk("op_x", bus.o_op_x, m_x);
    if (stage == 1) begin
      chk("err_x", {bus.o_error, bus.o_err_code, bus.o_core_start}, {1'b1, 2'(code), 1'b0});
      clear_err();
      return;
    end
    if (op == 2) begin
      m_y = '0;
    end else begin
      load_operand(y); m_y = y;
      if (stage == 2) begin
        chk("op_y", bus.o_op_y, m_y);
        chk("err_y", {bus.o_error, bus.o_err_code, bus.o_core_start}, {1'b1, 2'(code), 1'b0});
        clear_err();
        return;
      end
    end
    chk("op_y", bus.o_op_y, m_y);
    chk("launch", {bus.o_core_start, bus.o_busy}, 2'b11);
    launched = 1'b1;
  endtask

  task automatic run_txn(input int op, input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
    bit launched;
    int starts = 0, dones = 0;
    issue(op, x, y, launched);
    if (!launched) return;
    for (int t = 1; t <= lat; t++) begin
      tick();
      starts += int'(bus.o_core_start); dones += int'(bus.o_done);
      bus.i_core_ready = (t == lat);
    end
    tick(); bus.i_core_ready = 1'b0;
    chk("done", {bus.o_done, bus.o_error, bus.o_busy}, 3'b100);
    chk("single_launch", starts, 0);
    chk("no_early_done", dones, 0);
    chk("hold_xy", {bus.o_op_x, bus.o_op_y}, {m_x, m_y});
    tick();
    chk("back_idle", {bus.o_done, bus.o_busy, bus.o_error}, 0);
  endtask

  task automatic reset_abort(input bit in_launch);
    bit launched;
    int pulses = 0;
    issue(0, W'(7), W'(9), launched);
    if (!in_launch) begin tick(); tick(); end
    reset = 1'b1;
    #1;
    chk("rst_masks_pulse", bus.o_core_start, 0);
    tick(); reset = 1'b0;
    chk("abort_ctl", {bus.o_core_start, bus.o_busy, bus.o_done, bus.o_error,
                      bus.o_err_code, bus.o_core_opcode}, 0);
    chk("abort_ops", {bus.o_op_x, bus.o_op_y}, 0);
    m_x = '0; m_y = '0;
    bus.i_core_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.o_done) + int'(bus.o_core_start) + int'(bus.o_busy);
    end
    quiet();
    chk("abort_quiet", pulses, 0);
  endtask

  initial begin
    bit launched;
    int first;
    int other;
    reset = 1'b1;
    bus.i_opcode = 2'b00; bus.i_data = '0;
    quiet();
    tick();
    do_reset();

    run_txn(0, W'(100), W'(200), 3);
    run_txn(1, W'(50), W'(0), 1);
    run_txn(2, W'(16'h8000), W'(0), 1);
    run_txn(2, W'(16'h0010), W'(0), 2);
    run_txn(3, W'(1), W'(1), 1);
    run_txn(0, W'(HALF), W'(HALF), 1);
    run_txn(0, W'(HALF + 1), W'(1), 1);
    run_txn(0, W'(1), W'(HALF + 1), 1);
    run_txn(2, W'(HALF - 1), W'(5), 1);
    reset_abort(1'b0);
    reset_abort(1'b1);

    for (int i = 0; i < 60; i++) begin
      idle_gap();
      run_txn($urandom_range(0, 3), pick(), pick(), $urandom_range(1, 6));
    end

`ifdef MDR_SEQ_WATCHDOG_EN
    issue(1, W'(3), W'(3), launched);
    first = 0;
    for (int t = 1; t <= 100 && first == 0; t++) begin
      tick();
      if (bus.o_error) first = t;
    end
    chk("wd_cycle", first, TO + 1);
    chk("wd_code", bus.o_err_code, 3);
    clear_err();

    issue(1, W'(3), W'(3), launched);
    first = 0; other = 0;
    for (int t = 1; t <= TO + 2 && first == 0; t++) begin
      tick();
      other += int'(bus.o_error);
      if (bus.o_done) first = t;
      bus.i_core_ready = (t == TO);
    end
    quiet();
    chk("wd_ready_wins", first, TO + 1);
    chk("wd_no_error", other, 0);
    tick();
`else
    issue(1, W'(3), W'(3), launched);
    other = 0;
    for (int t = 1; t <= 2 * TO; t++) begin
      tick();
      other += int'(bus.o_error);
    end
    chk("no_wd_still_busy", bus.o_busy, 1);
    chk("no_wd_error", other, 0);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end
endmodule
`default_nettype wire

// File: doc/mdr_sequencer.md
MDR_SEQUENCER -- requirements
Module: mdr_sequencer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter WORD_LENGTH SHALL default to 16 and set the operand width.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 64 and set the watchdog limit in cycles.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high; forces the reset state on the next rising clk.
REQ-006 start  in  1  request for a new operation; sampled only in IDLE and ERR.
REQ-007 opcode  in  2  operation select: 00 multiply, 01 divide, 10 square root, 11 illegal.
REQ-008 load_data  in  1  operand strobe; data is valid when high.
REQ-009 data  in  WORD_LENGTH  operand input.
REQ-010 core_ready  in  1  arithmetic core reports that its result is valid.
REQ-011 core_start  out  1  one-cycle launch pulse to the arithmetic core.
REQ-012 core_opcode  out  2  latched opcode driven to the core.
REQ-013 op_x, op_y  out  WORD_LENGTH each  latched operands.
REQ-014 busy  out  1  high in LOAD_X, LOAD_Y, LAUNCH and WAIT.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 error  out  1  high while in ERR.
REQ-017 err_code  out  2  error cause: 00 none, 01 illegal opcode, 10 operand out of range, 11 timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD_X, LOAD_Y, LAUNCH, WAIT, DONE and ERR; all outputs SHALL be registered or decoded from the state.
REQ-019 IDLE with start=1 SHALL latch opcode into core_opcode and move to LOAD_X; with opcode=11 it SHALL instead move to ERR with err_code=01.
REQ-020 Any load_data asserted in the same cycle as start SHALL be ignored; operands SHALL be latched only in LOAD_X or LOAD_Y.
REQ-021 LOAD_X with load_data=1 SHALL latch data into op_x.
REQ-022 From LOAD_X, multiply SHALL go to ERR with err_code=10 if data is greater than 2^(WORD_LENGTH-1), unsigned; otherwise it SHALL go to LOAD_Y.
REQ-023 From LOAD_X, divide SHALL go to LOAD_Y.
REQ-024 From LOAD_X, square root SHALL go to ERR with err_code=10 if data[WORD_LENGTH-1]=1; otherwise it SHALL clear op_y to 0 and go to LAUNCH.
REQ-025 LOAD_Y with load_data=1 SHALL latch data into op_y.
REQ-026 From LOAD_Y, multiply SHALL apply the range check of REQ-022 to op_y.
REQ-027 From LOAD_Y, divide SHALL go to ERR with err_code=10 if data is 0.
REQ-028 From LOAD_Y, if no error applies, the FSM SHALL go to LAUNCH.
REQ-029 LAUNCH SHALL assert core_start for exactly one cycle and go to WAIT.
REQ-030 WAIT SHALL go to DONE on the cycle core_ready=1.
REQ-031 DONE SHALL assert done for one cycle and return to IDLE; the minimum latency from start to done for a two-operand operation with back-to-back load_data SHALL be 5 cycles plus the core latency.
REQ-032 While start=0 in IDLE or ERR, load_data and core_ready SHALL be ignored; start SHALL be ignored in all other states.
REQ-033 ERR SHALL hold error=1 and err_code until start=1, which SHALL clear both and return to IDLE without beginning a new operation.
REQ-034 op_x, op_y and core_opcode SHALL hold their values until they are next latched.

Reset
REQ-035 When reset=1, the FSM SHALL enter IDLE at the next clk edge and op_x, op_y, core_opcode and err_code SHALL become 0.
REQ-036 When reset=1, core_start, busy, done and error SHALL become 0.
REQ-037 Reset SHALL take priority over every other input.
REQ-038 Reset asserted during an operation SHALL abort it with no core_start or done pulse, including when reset arrives in LAUNCH.

Configuration
REQ-039 When macro MDR_SEQ_WATCHDOG_EN is defined, a counter SHALL clear on entry to WAIT and increment every cycle spent in WAIT.
REQ-040 With MDR_SEQ_WATCHDOG_EN defined, reaching TIMEOUT_CYCLES without core_ready SHALL move the FSM to ERR with err_code=11.
REQ-041 With MDR_SEQ_WATCHDOG_EN defined, if core_ready=1 in the same cycle as the timeout, the FSM SHALL go to DONE.
REQ-042 When MDR_SEQ_WATCHDOG_EN is undefined, WAIT SHALL wait indefinitely, err_code=11 SHALL never be produced, and no counter logic SHALL be synthesised.

Verification
REQ-043 Multiply: opcode=00, x=100, y=200, core_ready 3 cycles after core_start -> one core_start pulse, op_x=100, op_y=200, done pulse, error=0.
REQ-044 Divide by zero: opcode=01, x=50, y=0 -> ERR, error=1, err_code=10, no core_start; a later start=1 -> IDLE with error=0.
REQ-045 Square root: opcode=10, x=16'h8000 -> ERR with err_code=10; with x=16'h0010 -> op_y=0, core_start is asserted, done follows.
REQ-046 Illegal opcode: start=1 with opcode=11 -> error=1 and err_code=01 on the next cycle.
REQ-047 Reset during WAIT, and reset during LAUNCH -> IDLE with all outputs 0 and no done pulse.
REQ-048 With MDR_SEQ_WATCHDOG_EN defined and core_ready held at 0 -> err_code=11 exactly 64 cycles after entering WAIT.
REQ-049 With MDR_SEQ_WATCHDOG_EN defined and core_ready=1 on cycle 64 -> done is asserted and error stays 0.
